fib_sched: RTL and testbench

FIB_SCHED -- requirements
Module: fib_sched

---
 rtl/fib_pkg.sv | 16 +
 rtl/fib_sched_if.sv | 41 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/fib_sched.sv | 97 +++++++++
 tb/tb_fib_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: definitions shared by the fib request scheduler and its interface.
//   FIB_WIDTH : default operand/result width, matching the fib engine
//   state_t   : scheduler FSM state encoding
package fib_pkg;

  localparam int FIB_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fib_sched_if.sv
// fib_sched_if: requester-side and engine-side signals of the fib scheduler.
//   i_req_stb    : per-requester one-cycle request strobe
//   i_req_n      : per-requester operand, slice k = [k*WIDTH +: WIDTH]
//   o_req_pend   : request k accepted and not yet completed
//   o_done       : one-cycle completion pulse per requester
//   o_result     : registered result, valid with o_done, held afterwards
//   o_fib_stb    : start strobe to the engine
//   o_fib_n      : operand to the engine
//   i_fib_busy   : engine busy
//   i_fib_result : engine result
//   o_busy       : scheduler not idle
// Modports: slave = scheduler side, master = surrounding system side.
interface fib_sched_if
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int NREQ  = 4
);

  logic [NREQ-1:0]       i_req_stb;
  logic [NREQ*WIDTH-1:0] i_req_n;
  logic [NREQ-1:0]       o_req_pend;
  logic [NREQ-1:0]       o_done;
  logic [WIDTH-1:0]      o_result;
  logic                  o_fib_stb;
  logic [WIDTH-1:0]      o_fib_n;
  logic                  i_fib_busy;
  logic [WIDTH-1:0]      i_fib_result;
  logic                  o_busy;

  modport slave (
    input  i_req_stb, i_req_n, i_fib_busy, i_fib_result,
    output o_req_pend, o_done, o_result, o_fib_stb, o_fib_n, o_busy
  );

  modport master (
    output i_req_stb, i_req_n, i_fib_busy, i_fib_result,
    input  o_req_pend, o_done, o_result, o_fib_stb, o_fib_n, o_busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   pend       : pending request vector
//   last_grant : index served most recently
//   grant      : first pending index after last_grant, wrapping NREQ-1 -> 0
//   valid      : at least one request pending
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         pend,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    valid
);

  localparam int IDXW = $clog2(NREQ);

  logic [NREQ-1:0] rot;

  // Rotate so bit 0 is the requester right after last_grant; the lowest
  // set bit of rot is then the round-robin winner. Scanning downwards lets
  // the lowest hit overwrite any higher one.
  always_comb begin
    rot   = NREQ'({pend, pend} >> (int'(last_grant) + 1));
    grant = '0;
    valid = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (((rot >> j) & NREQ'(1)) != '0) begin
        valid = 1'b1;
        grant = IDXW'((int'(last_grant) + 1 + j) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fib_sched.sv
// fib_sched: shares one external fib engine among NREQ requesters.
//   i_clk   : clock, all state on rising edge
//   i_reset : asynchronous active-high reset
//   bus     : fib_sched_if.slave (request strobes/operands, completion
//             pulses, result, engine start/operand/busy/result, o_busy)
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | no job; pick next pending requester round-robin
// ST_ISSUE | strobe engine with operand[grant]
// ST_WAIT  | one cycle to cover engine busy latency
// ST_RUN   | wait for engine busy low, capture result
// ST_DONE  | pulse o_done[grant], free the slot
module fib_sched
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int NREQ  = 4
) (
  input logic        i_clk,
  input logic        i_reset,
  fib_sched_if.slave bus
);

  localparam int IDXW = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [NREQ-1:0]  pend;
  logic [WIDTH-1:0] operand [NREQ];
  logic [IDXW-1:0]  grant, last_grant, arb_grant;
  logic             arb_valid;
  logic [WIDTH-1:0] result;
  logic [NREQ-1:0]  done_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .pend       (pend),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (arb_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_RUN;
      ST_RUN:   if (!bus.i_fib_busy) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      grant      <= '0;
      last_grant <= IDXW'(NREQ - 1);
      result     <= '0;
    end else begin
      if (state == ST_IDLE && arb_valid)       grant      <= arb_grant;
      if (state == ST_RUN && !bus.i_fib_busy)  result     <= bus.i_fib_result;
      if (state == ST_DONE)                    last_grant <= grant;
    end
  end

  assign done_sel = (state == ST_DONE) ? (NREQ'(1) << grant) : '0;

  // A strobe in the same cycle its slot completes is accepted as a new job:
  // the set branch wins over the clear.
  for (genvar k = 0; k < NREQ; k++) begin : g_slot
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        pend[k]    <= 1'b0;
        operand[k] <= '0;
      end else if (bus.i_req_stb[k] && (!pend[k] || done_sel[k])) begin
        pend[k]    <= 1'b1;
        operand[k] <= bus.i_req_n[k*WIDTH +: WIDTH];
      end else if (done_sel[k]) begin
        pend[k]    <= 1'b0;
      end
    end
  end

  assign bus.o_req_pend = pend;
  assign bus.o_done     = done_sel;
  assign bus.o_result   = result;
  assign bus.o_fib_stb  = (state == ST_ISSUE);
  assign bus.o_fib_n    = (state == ST_ISSUE || state == ST_WAIT || state == ST_RUN)
                          ? operand[grant] : '0;
  assign bus.o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: directed table, corner-case sequences and a randomized run
// checked against a transaction-level scoreboard, with a behavioural engine.
module tb_fib_sched;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fib_sched_if #(.WIDTH(W), .NREQ(N)) bus ();

  fib_sched #(.WIDTH(W), .NREQ(N)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] nval [N];
  assign bus.i_req_n = {nval[3], nval[2], nval[1], nval[0]};

  function automatic logic [W-1:0] fib(input logic [W-1:0] n);
    logic [W-1:0] a, b, t;
    a = '0;
    b = 8'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural fib engine ----------------
  // busy rises the cycle after the strobe and stays high for eng_lat cycles;
  // the result is junk while busy and correct once busy drops.
  int           eng_lat;
  int           eng_cnt;
  logic [W-1:0] eng_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt          <= 0;
      eng_n            <= '0;
      bus.i_fib_busy   <= 1'b0;
      bus.i_fib_result <= '0;
    end else if (bus.o_fib_stb) begin
      eng_cnt <= eng_lat;
      eng_n   <= bus.o_fib_n;
      if (eng_lat == 0) begin
        bus.i_fib_busy   <= 1'b0;
        bus.i_fib_result <= fib(bus.o_fib_n);
      end else begin
        bus.i_fib_busy   <= 1'b1;
        bus.i_fib_result <= 8'hA5;
      end
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        bus.i_fib_busy   <= 1'b0;
        bus.i_fib_result <= fib(eng_n);
      end
    end
  end

  // ---------------- scoreboard for the random run ----------------
  logic [N-1:0] pend_m, pend_prev;
  logic [W-1:0] op_m [N];
  int           last_m, cur_g, m_g;
  bit           inflight, m_done_now, rnd_on;

  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last + i) % N;
      if (((p >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rnd_on) begin
      chk("rnd_pend", 32'(bus.o_req_pend), 32'(pend_m));
      m_done_now = 1'b0;
      if (bus.o_fib_stb) begin
        m_g = rr_pick(pend_prev, last_m);
        chk("rnd_issue_legal", 32'(!inflight && m_g >= 0), 32'd1);
        if (!inflight && m_g >= 0) begin
          chk("rnd_issue_n", 32'(bus.o_fib_n), 32'(op_m[m_g]));
          inflight = 1'b1;
          cur_g    = m_g;
        end
      end
      if (bus.o_done != '0) begin
        chk("rnd_done_sel", 32'(bus.o_done), inflight ? 32'(1 << cur_g) : 32'd0);
        if (inflight && 32'(bus.o_done) == 32'(1 << cur_g)) begin
          chk("rnd_result", 32'(bus.o_result), 32'(fib(op_m[cur_g])));
          m_done_now = 1'b1;
        end
      end
      pend_prev = pend_m;
      for (int k = 0; k < N; k++) begin
        if (bus.i_req_stb[k] && (!pend_m[k] || (m_done_now && cur_g == k))) begin
          pend_m[k] = 1'b1;
          op_m[k]   = nval[k];
        end else if (m_done_now && cur_g == k) begin
          pend_m[k] = 1'b0;
        end
      end
      if (m_done_now) begin
        last_m   = cur_g;
        inflight = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    bus.i_req_stb = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_one(input int k, input logic [W-1:0] n, input int lat,
                         output logic [N-1:0] dv, output logic [W-1:0] res,
                         output int cyc, output logic [W-1:0] isn);
    dv  = '0;
    res = '0;
    cyc = 0;
    isn = '0;
    eng_lat = lat;
    nval[k] = n;
    bus.i_req_stb = N'(1 << k);
    for (int c = 1; c <= 40; c++) begin
      tick();
      bus.i_req_stb = '0;
      if (bus.o_fib_stb) isn = bus.o_fib_n;
      if (bus.o_done != '0) begin
        dv  = bus.o_done;
        res = bus.o_result;
        cyc = c;
        break;
      end
    end
  endtask

  task automatic next_done(output logic [N-1:0] dv, output logic [W-1:0] res);
    dv  = '0;
    res = '0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (bus.o_done != '0) begin
        dv  = bus.o_done;
        res = bus.o_result;
        break;
      end
    end
  endtask

  typedef struct {
    int           k;
    logic [W-1:0] n;
    int           lat;
    logic [W-1:0] exp_res;
    int           exp_cyc;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] dv;
    logic [W-1:0] res, isn;
    int           cyc, ndone, nstb;
    logic [N-1:0] ord_dv [4];
    logic [W-1:0] ord_res [4];

    tbl[0] = '{0, 8'd10, 2, 8'd55,  6};
    tbl[1] = '{1, 8'd0,  0, 8'd0,   5};
    tbl[2] = '{2, 8'd13, 3, 8'd233, 7};
    tbl[3] = '{3, 8'd14, 1, 8'd121, 5};
    tbl[4] = '{0, 8'd1,  0, 8'd1,   5};
    tbl[5] = '{1, 8'd20, 4, 8'd109, 8};

    bus.i_req_stb = '0;
    for (int k = 0; k < N; k++) nval[k] = '0;
    eng_lat = 0;
    rnd_on  = 1'b0;

    // reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst_pend",    32'(bus.o_req_pend), 32'd0);
    chk("rst_done",    32'(bus.o_done),     32'd0);
    chk("rst_result",  32'(bus.o_result),   32'd0);
    chk("rst_fib_stb", 32'(bus.o_fib_stb),  32'd0);
    chk("rst_busy",    32'(bus.o_busy),     32'd0);
    chk("rst_fib_n",   32'(bus.o_fib_n),    32'd0);
    rst = 1'b0;
    tick();

    // single-request table, including n=0 with immediate busy drop
    for (int i = 0; i < 6; i++) begin
      run_one(tbl[i].k, tbl[i].n, tbl[i].lat, dv, res, cyc, isn);
      chk("tbl_done",   32'(dv),  32'(1 << tbl[i].k));
      chk("tbl_result", 32'(res), 32'(tbl[i].exp_res));
      chk("tbl_cycles", 32'(cyc), 32'(tbl[i].exp_cyc));
      chk("tbl_fib_n",  32'(isn), 32'(tbl[i].n));
      tick();
      chk("tbl_idle_after", 32'({bus.o_busy, bus.o_done}), 32'd0);
    end

    // simultaneous requests on all four
    do_reset();
    eng_lat = 1;
    nval[0] = 8'd1; nval[1] = 8'd2; nval[2] = 8'd3; nval[3] = 8'd7;
    bus.i_req_stb = 4'hF;
    tick();
    bus.i_req_stb = '0;
    for (int j = 0; j < 4; j++) next_done(ord_dv[j], ord_res[j]);
    chk("sim_done0", 32'(ord_dv[0]), 32'd1);
    chk("sim_res0",  32'(ord_res[0]), 32'd1);
    chk("sim_done1", 32'(ord_dv[1]), 32'd2);
    chk("sim_res1",  32'(ord_res[1]), 32'd1);
    chk("sim_done2", 32'(ord_dv[2]), 32'd4);
    chk("sim_res2",  32'(ord_res[2]), 32'd2);
    chk("sim_done3", 32'(ord_dv[3]), 32'd8);
    chk("sim_res3",  32'(ord_res[3]), 32'd13);

    // fairness: req1 re-strobes in its own DONE cycle while req2 waits
    do_reset();
    eng_lat = 2;
    nval[1] = 8'd4;
    bus.i_req_stb = 4'b0010;
    tick();
    bus.i_req_stb = '0;
    tick();
    nval[2] = 8'd5;
    bus.i_req_stb = 4'b0100;
    tick();
    bus.i_req_stb = '0;
    next_done(dv, res);
    chk("fair_done_a", 32'(dv),  32'd2);
    chk("fair_res_a",  32'(res), 32'd3);
    nval[1] = 8'd6;
    bus.i_req_stb = 4'b0010;
    tick();
    bus.i_req_stb = '0;
    chk("fair_pend", 32'(bus.o_req_pend), 32'b0110);
    next_done(dv, res);
    chk("fair_done_b", 32'(dv),  32'd4);
    chk("fair_res_b",  32'(res), 32'd5);
    next_done(dv, res);
    chk("fair_done_c", 32'(dv),  32'd2);
    chk("fair_res_c",  32'(res), 32'd8);

    // strobe while pending is ignored
    do_reset();
    eng_lat = 1;
    nval[3] = 8'd5;
    bus.i_req_stb = 4'b1000;
    tick();
    nval[3] = 8'd9;
    tick();
    bus.i_req_stb = '0;
    ndone = 0;
    nstb  = 0;
    isn   = '0;
    res   = '0;
    for (int c = 0; c < 30; c++) begin
      if (bus.o_fib_stb) begin
        nstb++;
        isn = bus.o_fib_n;
      end
      if (bus.o_done[3]) begin
        ndone++;
        res = bus.o_result;
      end
      tick();
    end
    chk("pendstb_issues", 32'(nstb),  32'd1);
    chk("pendstb_fib_n",  32'(isn),   32'd5);
    chk("pendstb_done",   32'(ndone), 32'd1);
    chk("pendstb_result", 32'(res),   32'd5);

    // reset during RUN
    do_reset();
    eng_lat = 6;
    nval[0] = 8'd12;
    bus.i_req_stb = 4'b0001;
    tick();
    bus.i_req_stb = '0;
    tick();
    tick();
    tick();
    chk("rrun_busy", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rrun_outs", 32'({bus.o_req_pend, bus.o_done, bus.o_fib_stb, bus.o_busy}), 32'd0);
    chk("rrun_fib_n", 32'(bus.o_fib_n), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    nstb  = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.o_done != '0) ndone++;
      if (bus.o_fib_stb)    nstb++;
    end
    chk("rrun_no_done", 32'(ndone), 32'd0);
    chk("rrun_no_stb",  32'(nstb),  32'd0);
    run_one(0, 8'd6, 1, dv, res, cyc, isn);
    chk("rrun_after_done", 32'(dv),  32'd1);
    chk("rrun_after_res",  32'(res), 32'd8);

    // randomized traffic against the scoreboard
    do_reset();
    pend_m    = '0;
    pend_prev = '0;
    for (int k = 0; k < N; k++) op_m[k] = '0;
    last_m   = N - 1;
    cur_g    = 0;
    inflight = 1'b0;
    rnd_on   = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) nval[k] = W'($urandom_range(0, 30));
      bus.i_req_stb = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      eng_lat = $urandom_range(0, 4);
      tick();
    end
    bus.i_req_stb = '0;
    for (int c = 0; c < 400; c++) begin
      if (pend_m == '0 && !inflight) break;
      tick();
    end
    chk("rnd_drained",    32'(pend_m == '0 && !inflight), 32'd1);
    chk("rnd_drain_pend", 32'(bus.o_req_pend), 32'd0);
    chk("rnd_drain_busy", 32'(bus.o_busy),     32'd0);
    rnd_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
